// File: rtl/alut_age_checker_if.sv
// Single-port RAM bus between the age checker and the ALUT address table.
// The age checker is the master; the table RAM is the slave.
interface alut_age_checker_if #(
    parameter int unsigned AW    = 3,
    parameter int unsigned ENT_W = 83
);
    logic [AW-1:0]    mem_addr;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [ENT_W-1:0] mem_wr_data;
    logic [ENT_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/alut_age_checker.sv
// ALUT age checker: scans the address table once per command and clears the valid
// bit of aged entries (cmd 01) or of every valid entry (cmd 10).
module alut_age_checker #(
    parameter int unsigned AW    = 3,
    parameter int unsigned ENT_W = 83
) (
    input  logic                pclk,
    input  logic                p_reset,
    input  logic [1:0]          command,
    input  logic [31:0]         curr_time,
    input  logic [31:0]         best_bfr_age,
    input  logic                add_check_active,
    alut_age_checker_if.master  mem,
    output logic                age_check_active,
    output logic                inval_in_prog,
    output logic [47:0]         lst_inv_addr_cmd,
    output logic [1:0]          lst_inv_port_cmd
);

    localparam int unsigned ValidBit = ENT_W - 1;
    localparam int unsigned PortLsb  = ENT_W - 3;
    localparam int unsigned TsLsb    = 48;
    localparam logic [AW-1:0] LastIdx = {AW{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StRd,
        StChk,
        StWr
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             inval_all_q, inval_all_d;
    logic [31:0]      t_ref_q, t_ref_d;
    logic [31:0]      bba_q, bba_d;
    logic [ENT_W-1:0] entry_q, entry_d;
    logic [47:0]      lst_addr_q, lst_addr_d;
    logic [1:0]       lst_port_q, lst_port_d;

    logic [31:0]      age;
    logic             hit;

    // Modulo subtraction keeps the age correct across a wrap of curr_time.
    assign age = t_ref_q - mem.mem_rd_data[TsLsb +: 32];
    assign hit = mem.mem_rd_data[ValidBit] && (inval_all_q || (age > bba_q));

    // idx is forced back to 0 on every return to idle, so it doubles as the RAM index.
    assign mem.mem_addr     = idx_q;
    assign lst_inv_addr_cmd = lst_addr_q;
    assign lst_inv_port_cmd = lst_port_q;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        inval_all_d      = inval_all_q;
        t_ref_d          = t_ref_q;
        bba_d            = bba_q;
        entry_d          = entry_q;
        lst_addr_d       = lst_addr_q;
        lst_port_d       = lst_port_q;
        age_check_active = 1'b0;
        inval_in_prog    = 1'b0;
        mem.mem_rd_en    = 1'b0;
        mem.mem_wr_en    = 1'b0;
        mem.mem_wr_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (command == 2'b01 || command == 2'b10) begin
                    inval_all_d = (command == 2'b10);
                    t_ref_d     = curr_time;
                    bba_d       = best_bfr_age;
                    idx_d       = '0;
                    state_d     = StArb;
                end
            end
            StArb: begin
                age_check_active = 1'b1;
                if (!add_check_active) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                age_check_active = 1'b1;
                mem.mem_rd_en    = 1'b1;
                state_d          = StChk;
            end
            StChk: begin
                age_check_active = 1'b1;
                if (hit) begin
                    entry_d    = mem.mem_rd_data;
                    lst_addr_d = mem.mem_rd_data[47:0];
                    lst_port_d = mem.mem_rd_data[PortLsb +: 2];
                    state_d    = StWr;
                end else if (idx_q == LastIdx) begin
                    // Index advance happens on leaving CHK/WR: a clean entry costs 3 cycles.
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StArb;
                end
            end
            StWr: begin
                age_check_active          = 1'b1;
                inval_in_prog             = 1'b1;
                mem.mem_wr_en             = 1'b1;
                mem.mem_wr_data           = entry_q;
                mem.mem_wr_data[ValidBit] = 1'b0;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StArb;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            inval_all_q <= 1'b0;
            t_ref_q     <= '0;
            bba_q       <= '0;
            entry_q     <= '0;
            lst_addr_q  <= '0;
            lst_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inval_all_q <= inval_all_d;
            t_ref_q     <= t_ref_d;
            bba_q       <= bba_d;
            entry_q     <= entry_d;
            lst_addr_q  <= lst_addr_d;
            lst_port_q  <= lst_port_d;
        end
    end

endmodule

// File: tb/tb_alut_age_checker.sv
// Bench for alut_age_checker: single-entry vector table plus directed multi-cycle
// sequences (bulk invalidate, bus contention, reset mid-scan) against a RAM model.
module tb_alut_age_checker;
    localparam int unsigned AW    = 3;
    localparam int unsigned ENT_W = 83;
    localparam int unsigned DEPTH = 8;

    logic        pclk = 1'b0;
    logic        p_reset;
    logic [1:0]  command;
    logic [31:0] curr_time;
    logic [31:0] best_bfr_age;
    logic        add_check_active;
    logic        age_check_active;
    logic        inval_in_prog;
    logic [47:0] lst_inv_addr_cmd;
    logic [1:0]  lst_inv_port_cmd;

    always #5 pclk = ~pclk;

    alut_age_checker_if #(.AW(AW), .ENT_W(ENT_W)) mem_if ();

    alut_age_checker #(.AW(AW), .ENT_W(ENT_W)) dut (
        .pclk             (pclk),
        .p_reset          (p_reset),
        .command          (command),
        .curr_time        (curr_time),
        .best_bfr_age     (best_bfr_age),
        .add_check_active (add_check_active),
        .mem              (mem_if.master),
        .age_check_active (age_check_active),
        .inval_in_prog    (inval_in_prog),
        .lst_inv_addr_cmd (lst_inv_addr_cmd),
        .lst_inv_port_cmd (lst_inv_port_cmd)
    );

    // Table RAM model with one-cycle read latency and a bulk preload port.
    logic [ENT_W-1:0] ram     [DEPTH];
    logic [ENT_W-1:0] preload [DEPTH];
    logic             load_req;

    always @(posedge pclk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= preload[i];
        end else if (mem_if.mem_wr_en) begin
            ram[mem_if.mem_addr] <= mem_if.mem_wr_data;
        end
        if (mem_if.mem_rd_en) mem_if.mem_rd_data <= ram[mem_if.mem_addr];
    end

    // Monotonic activity counters; tests work on deltas.
    int          n_active = 0, n_rd = 0, n_wr = 0, n_pulse = 0, n_both = 0;
    logic [47:0] pulse_mac = '0;
    logic [1:0]  pulse_port = '0;

    always @(negedge pclk) begin
        if (age_check_active) n_active++;
        if (mem_if.mem_rd_en) n_rd++;
        if (mem_if.mem_wr_en) n_wr++;
        if (mem_if.mem_rd_en && mem_if.mem_wr_en) n_both++;
        if (inval_in_prog) begin
            n_pulse++;
            pulse_mac  = lst_inv_addr_cmd;
            pulse_port = lst_inv_port_cmd;
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    function automatic logic [ENT_W-1:0] mk(input logic v, input logic [1:0] p,
                                            input logic [31:0] ts, input logic [47:0] mac);
        return {v, p, ts, mac};
    endfunction

    task automatic load_table();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic to;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!age_check_active) begin
                to = 1'b0;
                break;
            end
            step();
        end
        check({name, "_timeout"}, to, 1'b0);
    endtask

    // Issues a one-cycle command, scrambles time inputs, waits for the scan to end.
    task automatic run_scan(input logic [1:0] c, input string name,
                            output int d_act, output int d_rd, output int d_wr,
                            output int d_pulse);
        int a0, r0, w0, p0;
        a0 = n_active; r0 = n_rd; w0 = n_wr; p0 = n_pulse;
        step();
        command = c;
        step();
        command      = 2'b00;
        curr_time    = 32'h7000_0000;
        best_bfr_age = 32'h0;
        wait_idle(name);
        repeat (2) step();
        d_act   = n_active - a0;
        d_rd    = n_rd - r0;
        d_wr    = n_wr - w0;
        d_pulse = n_pulse - p0;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] tref;
        logic [31:0] bba;
        logic        valid;
        logic [31:0] ts;
        logic [1:0]  port;
        logic [47:0] mac;
        logic        exp_inval;
        int          exp_active;
        int          exp_rd;
    } vec_t;

    vec_t        vecs [10];
    logic [47:0] exp_mac;
    logic [1:0]  exp_port;
    logic [ENT_W-1:0] exp_ent;
    int          d_act, d_rd, d_wr, d_pulse;
    int          r0, w0;
    logic        to;

    initial begin
        vecs[0] = '{2'b01, 32'd1000, 32'd100, 1'b1, 32'd899, 2'd1, 48'h0A00_0000_0001, 1'b1, 25, 8};
        vecs[1] = '{2'b01, 32'd1000, 32'd100, 1'b1, 32'd900, 2'd2, 48'h0A00_0000_0002, 1'b0, 24, 8};
        vecs[2] = '{2'b01, 32'd1000, 32'd100, 1'b1, 32'd950, 2'd3, 48'h0A00_0000_0003, 1'b0, 24, 8};
        vecs[3] = '{2'b01, 32'h10, 32'h1F, 1'b1, 32'hFFFF_FFF0, 2'd2, 48'hBEEF_0000_0004, 1'b1, 25, 8};
        vecs[4] = '{2'b01, 32'h10, 32'h20, 1'b1, 32'hFFFF_FFF0, 2'd1, 48'hBEEF_0000_0005, 1'b0, 24, 8};
        vecs[5] = '{2'b10, 32'd1000, 32'd100, 1'b1, 32'd950, 2'd0, 48'hCAFE_0000_0006, 1'b1, 25, 8};
        vecs[6] = '{2'b10, 32'd1000, 32'd100, 1'b0, 32'd950, 2'd1, 48'hCAFE_0000_0007, 1'b0, 24, 8};
        vecs[7] = '{2'b01, 32'd1000, 32'd1, 1'b0, 32'd0, 2'd2, 48'hCAFE_0000_0008, 1'b0, 24, 8};
        vecs[8] = '{2'b00, 32'd1000, 32'd1, 1'b1, 32'd0, 2'd3, 48'hCAFE_0000_0009, 1'b0, 0, 0};
        vecs[9] = '{2'b11, 32'd1000, 32'd1, 1'b1, 32'd0, 2'd3, 48'hCAFE_0000_000A, 1'b0, 0, 0};

        p_reset = 1'b1; command = 2'b00; curr_time = '0; best_bfr_age = '0;
        add_check_active = 1'b0; load_req = 1'b0;
        #1;
        check("rst_active", age_check_active, 1'b0);
        check("rst_rd_en", mem_if.mem_rd_en, 1'b0);
        check("rst_wr_en", mem_if.mem_wr_en, 1'b0);
        check("rst_addr", mem_if.mem_addr, 3'd0);
        check("rst_lst", {lst_inv_addr_cmd, lst_inv_port_cmd}, 50'd0);
        repeat (2) step();
        p_reset  = 1'b0;
        exp_mac  = '0;
        exp_port = '0;

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < DEPTH; i++) preload[i] = mk(1'b0, 2'd3, 32'd0, 48'hF00 + 48'(i));
            preload[0] = mk(vecs[v].valid, vecs[v].port, vecs[v].ts, vecs[v].mac);
            load_table();
            curr_time    = vecs[v].tref;
            best_bfr_age = vecs[v].bba;
            run_scan(vecs[v].cmd, $sformatf("v%0d", v), d_act, d_rd, d_wr, d_pulse);
            exp_ent = mk(vecs[v].valid & ~vecs[v].exp_inval, vecs[v].port, vecs[v].ts, vecs[v].mac);
            if (vecs[v].exp_inval) begin
                exp_mac  = vecs[v].mac;
                exp_port = vecs[v].port;
            end
            check($sformatf("v%0d_active_cycles", v), d_act, vecs[v].exp_active);
            check($sformatf("v%0d_reads", v), d_rd, vecs[v].exp_rd);
            check($sformatf("v%0d_writes", v), d_wr, 32'(vecs[v].exp_inval));
            check($sformatf("v%0d_pulses", v), d_pulse, 32'(vecs[v].exp_inval));
            check($sformatf("v%0d_entry0", v), ram[0], exp_ent);
            check($sformatf("v%0d_entry5", v), ram[5], mk(1'b0, 2'd3, 32'd0, 48'hF05));
            check($sformatf("v%0d_lst", v), {lst_inv_addr_cmd, lst_inv_port_cmd},
                  {exp_mac, exp_port});
            if (vecs[v].exp_inval)
                check($sformatf("v%0d_lst_at_pulse", v), {pulse_mac, pulse_port},
                      {exp_mac, exp_port});
            check($sformatf("v%0d_idle_addr", v), mem_if.mem_addr, 3'd0);
        end

        // Invalidate-all with entries 0,2,3,5,7 valid.
        for (int i = 0; i < DEPTH; i++)
            preload[i] = mk((i == 0 || i == 2 || i == 3 || i == 5 || i == 7), 2'(i),
                            32'd100 + 32'(i), 48'hAB00 + 48'(i));
        load_table();
        curr_time = 32'd50; best_bfr_age = 32'hFFFF_FFFF;
        run_scan(2'b10, "all", d_act, d_rd, d_wr, d_pulse);
        check("all_writes", d_wr, 5);
        check("all_pulses", d_pulse, 5);
        check("all_active_cycles", d_act, 29);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("all_entry%0d", i), ram[i],
                  mk(1'b0, 2'(i), 32'd100 + 32'(i), 48'hAB00 + 48'(i)));
        check("all_lst", {lst_inv_addr_cmd, lst_inv_port_cmd}, {48'hAB07, 2'd3});

        // Contention: address checker holds the bus 10 cycles; a mid-scan command is ignored.
        for (int i = 0; i < DEPTH; i++) preload[i] = mk(1'b0, 2'd0, 32'd0, 48'h0);
        load_table();
        r0 = n_rd; w0 = n_active;
        step();
        command = 2'b01;
        step();
        command = 2'b00;
        add_check_active = 1'b1;
        repeat (10) step();
        check("arb_no_read", n_rd - r0, 0);
        check("arb_active", age_check_active, 1'b1);
        add_check_active = 1'b0;
        repeat (6) step();
        command = 2'b01;
        step();
        command = 2'b00;
        wait_idle("arb");
        check("arb_active_cycles", n_active - w0, 34);
        check("arb_reads", n_rd - r0, 8);

        // Reset while entry 3 is being read.
        for (int i = 0; i < DEPTH; i++) preload[i] = mk(1'b1, 2'd1, 32'd0, 48'h5500 + 48'(i));
        load_table();
        curr_time = 32'd1000; best_bfr_age = 32'd10;
        step();
        command = 2'b01;
        step();
        command = 2'b00;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (mem_if.mem_rd_en && mem_if.mem_addr == 3'd3) begin
                to = 1'b0;
                break;
            end
            step();
        end
        check("rst_mid_timeout", to, 1'b0);
        p_reset = 1'b1;
        w0 = n_wr;
        #1;
        check("rst_mid_outputs",
              {age_check_active, inval_in_prog, mem_if.mem_rd_en, mem_if.mem_wr_en,
               mem_if.mem_addr, lst_inv_addr_cmd, lst_inv_port_cmd}, 57'd0);
        repeat (2) step();
        check("rst_mid_no_write", n_wr - w0, 0);
        p_reset = 1'b0;
        check("rst_mid_entry2", ram[2], mk(1'b0, 2'd1, 32'd0, 48'h5502));
        check("rst_mid_entry3", ram[3], mk(1'b1, 2'd1, 32'd0, 48'h5503));
        run_scan(2'b10, "post_rst", d_act, d_rd, d_wr, d_pulse);
        check("post_rst_writes", d_wr, 5);
        check("post_rst_active_cycles", d_act, 29);
        check("post_rst_lst", {lst_inv_addr_cmd, lst_inv_port_cmd}, {48'h5507, 2'd1});
        check("rd_wr_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
